alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares one 32-bit combinational ALU between two requester ports (port 0, port 1).
- Each port issues operations through a req/gnt handshake and receives its result in a per-port registered slot, drained with rsp_valid/rsp_ready.
- Grants use a round-robin pointer, so neither port starves.
- Sits between the multi-cycle control unit's issue logic and the shared ALU datapath.

Parameters:
- WIDTH, 32, operand and result width.
- FAIR_RESET_PRI, 0, port that holds priority after reset (0 or 1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req0, req1  input  1 each  port n requests an operation.
- a0, a1  input  WIDTH each  operand A for port n.
- b0, b1  input  WIDTH each  operand B for port n.
- op0, op1  input  3 each  ALU opcode for port n.
- gnt0, gnt1  output  1 each  operation accepted this cycle (combinational).
- rsp_valid0, rsp_valid1  output  1 each  result slot of port n is full.
- rsp_ready0, rsp_ready1  input  1 each  port n consumes its slot this cycle.
- res0, res1  output  WIDTH each  registered result for port n.

Behaviour:
- Opcodes:
  - 000 A+B
  - 001 A-B
  - 010 A&B
  - 011 A|B
  - 100 logical A>>B
  - 101 arithmetic A>>>B
  - 110/111 result 0
- Add and sub wrap modulo 2^WIDTH.
- Shifts use the full B value:
  - B>=WIDTH gives 0 for 100.
  - B>=WIDTH gives WIDTH copies of A[WIDTH-1] for 101.
- Eligibility: port n is eligible when reqn=1 AND its slot is free. A slot is free when rsp_validn=0, or when rsp_validn=1 and rsp_readyn=1 in the same cycle (drain-and-refill).
- Arbitration:
  - At most one grant per cycle.
  - If only one port is eligible, it is granted.
  - If both are eligible, the port named by pointer prio is granted.
  - gnt is a combinational function of current inputs and state.
- Pointer: on any grant, prio <= the other port. With no grant, prio holds.
- Handshake:
  - A requester keeps reqn, an, bn and opn stable until it sees gntn=1.
  - gnt lasts exactly that cycle.
  - Deasserting req before grant is legal and withdraws the request.
- Latency: the ALU result is captured into resn at the clock edge ending the grant cycle. rsp_validn=1 from the next cycle, so the result is visible 1 cycle after the grant.
- Slot update at each edge, in priority order:
  - gntn: rsp_validn <= 1, resn <= ALU result.
  - else rsp_readyn && rsp_validn: rsp_validn <= 0 and resn holds its last value.
  - else hold.
- rsp_readyn while rsp_validn=0 is ignored.
- Full slot and reqn=1 without rsp_readyn: no grant to port n. The other port may be granted and the pointer advances normally.
- Simultaneous drain on port 0 and grant on port 1: both take effect independently.
- Reset (synchronous, valid at any time, including mid-handshake):
  - rsp_valid0/1 <= 0, res0/1 <= 0, prio <= FAIR_RESET_PRI.
  - gnt0/1 are forced to 0 while reset=1.
  - In-flight results are discarded.
- Every output is defined after the first reset edge. gnt is 0 whenever no port is eligible.

Optional Feature:
- Macro ALU_ARB_OPERR_EN.
- When defined:
  - Adds outputs operr0 and operr1 (1 bit each), registered alongside resn.
  - operrn <= 1 when the granted opcode is 110 or 111, and clears on drain.
  - Reset value is 0.
  - resn is still 0 for these opcodes.
- When undefined: no operr ports exist and illegal opcodes silently return 0.

Test Plan:
- Single port: reset, then req0=1, a0=5, b0=3, op0=001 with rsp_ready0=1 → gnt0=1 for one cycle. Next cycle rsp_valid0=1, res0=2. Cycle after that rsp_valid0=0.
- Contention: both ports request every cycle with rsp_ready=1, FAIR_RESET_PRI=0 → grants alternate 0,1,0,1. Port 0 op 000 on 7,8 gives res0=15. Port 1 op 101 on 32'h80000000,4 gives res1=32'hF8000000.
- Backpressure: port 0 slot full with rsp_ready0=0 and req0=1 → gnt0 stays 0 and port 1 gets every grant. Raising rsp_ready0 gives a same-cycle drain+refill: gnt0=1 and rsp_valid0 stays 1 with the new res0.
- Shift boundaries: op 100 with A=32'hFFFFFFFF, B=32 → 0. Op 101 with A=32'h80000000, B=40 → 32'hFFFFFFFF. Op 000 with A=32'hFFFFFFFF, B=1 → 0.
- Reset mid-operation: assert reset in the cycle after a grant while rsp_valid1=1 → next cycle rsp_valid0/1=0, res0/1=0, and the following contention grant goes to port FAIR_RESET_PRI.
- With ALU_ARB_OPERR_EN defined: op0=110 → res0=0 and operr0=1. After drain operr0=0. A legal op leaves operr0=0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two ports.
// Optional ALU_ARB_OPERR_EN adds per-port illegal-opcode flags (operr0/1).
module alu_arbiter #(
  parameter int WIDTH          = 32,
  parameter int FAIR_RESET_PRI = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] b1,
  input  logic [2:0]       op0,
  input  logic [2:0]       op1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             rsp_valid0,
  output logic             rsp_valid1,
  input  logic             rsp_ready0,
  input  logic             rsp_ready1,
  output logic [WIDTH-1:0] res0,
  output logic [WIDTH-1:0] res1
`ifdef ALU_ARB_OPERR_EN
  ,
  output logic             operr0,
  output logic             operr1
`endif
);

  localparam logic PRIO_INIT = (FAIR_RESET_PRI != 0);
  localparam logic [WIDTH-1:0] WLIM = WIDTH'(WIDTH);

  function automatic logic [WIDTH-1:0] alu(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic big;
    big = (b >= WLIM);
    alu = '0;
    case (op)
      3'b000: alu = a + b;
      3'b001: alu = a - b;
      3'b010: alu = a & b;
      3'b011: alu = a | b;
      3'b100: alu = big ? '0 : (a >> b);
      3'b101: alu = big ? {WIDTH{a[WIDTH-1]}}
                        : $unsigned($signed(a) >>> b);
      default: alu = '0;
    endcase
  endfunction

  logic             prio;
  logic             elig0;
  logic             elig1;
  logic [WIDTH-1:0] y0;
  logic [WIDTH-1:0] y1;

  // a full slot being drained this cycle may be refilled in the same cycle
  assign elig0 = req0 && (!rsp_valid0 || rsp_ready0);
  assign elig1 = req1 && (!rsp_valid1 || rsp_ready1);

  assign gnt0 = !reset && elig0 && (!elig1 || !prio);
  assign gnt1 = !reset && elig1 && (!elig0 || prio);

  assign y0 = alu(op0, a0, b0);
  assign y1 = alu(op1, a1, b1);

  always_ff @(posedge clk) begin
    if (reset) begin
      prio <= PRIO_INIT;
    end else if (gnt0 || gnt1) begin
      prio <= gnt0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid0 <= 1'b0;
      res0       <= '0;
    end else if (gnt0) begin
      rsp_valid0 <= 1'b1;
      res0       <= y0;
    end else if (rsp_ready0 && rsp_valid0) begin
      rsp_valid0 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid1 <= 1'b0;
      res1       <= '0;
    end else if (gnt1) begin
      rsp_valid1 <= 1'b1;
      res1       <= y1;
    end else if (rsp_ready1 && rsp_valid1) begin
      rsp_valid1 <= 1'b0;
    end
  end

`ifdef ALU_ARB_OPERR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      operr0 <= 1'b0;
      operr1 <= 1'b0;
    end else begin
      if (gnt0) begin
        operr0 <= (op0[2:1] == 2'b11);
      end else if (rsp_ready0 && rsp_valid0) begin
        operr0 <= 1'b0;
      end
      if (gnt1) begin
        operr1 <= (op1[2:1] == 2'b11);
      end else if (rsp_ready1 && rsp_valid1) begin
        operr1 <= 1'b0;
      end
    end
  end
`endif

endmodule
